// File: rtl/gelato_warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gelato_warp_scheduler
// Brief    : Per-SM warp scheduler; round-robin issue of READY warps to fetch
// Revision : 1.0
// ============================================================================
module gelato_warp_scheduler #(
    parameter int NUM_WARPS   = 4,
    parameter int WARP_W      = $clog2(NUM_WARPS),
    parameter int NUM_THREADS = 32,
    parameter int ADDR_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   launch_valid,
    output logic                   launch_ready,
    input  logic [WARP_W-1:0]      launch_warp_id,
    input  logic [ADDR_W-1:0]      launch_pc,
    input  logic [NUM_THREADS-1:0] launch_mask,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [WARP_W-1:0]      fetch_warp_id,
    output logic [ADDR_W-1:0]      fetch_pc,
    output logic [NUM_THREADS-1:0] fetch_mask,
    input  logic                   resume_valid,
    input  logic [WARP_W-1:0]      resume_warp_id,
    input  logic [ADDR_W-1:0]      resume_pc,
    input  logic [NUM_THREADS-1:0] resume_mask,
    input  logic                   exit_valid,
    input  logic [WARP_W-1:0]      exit_warp_id,
    output logic                   busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]             r_state [NUM_WARPS];
    logic [ADDR_W-1:0]      r_pc    [NUM_WARPS];
    logic [NUM_THREADS-1:0] r_mask  [NUM_WARPS];
    logic [WARP_W-1:0]      r_rr;
    logic [WARP_W-1:0]      r_lock_id;
    logic                   r_lock;

    logic                   w_any_ready;
    logic [WARP_W-1:0]      w_sel_id;
    logic [WARP_W-1:0]      w_idx;
    logic                   w_fire;
    logic                   w_busy;

    // Scan starting at the rr pointer; the index wraps naturally since NUM_WARPS is a power of 2.
    always_comb begin
        w_any_ready = 1'b0;
        w_sel_id    = r_rr;
        w_idx       = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_idx = r_rr + WARP_W'(i);
            if (!w_any_ready && r_state[w_idx] == ST_READY) begin
                w_any_ready = 1'b1;
                w_sel_id    = w_idx;
            end
        end
        if (r_lock) begin
            w_sel_id = r_lock_id;
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_busy = w_busy | (r_state[i] != ST_IDLE);
        end
    end

    assign launch_ready  = (r_state[launch_warp_id] == ST_IDLE);
    assign fetch_valid   = r_lock | w_any_ready;
    assign fetch_warp_id = fetch_valid ? w_sel_id : '0;
    assign fetch_pc      = fetch_valid ? r_pc[w_sel_id] : '0;
    assign fetch_mask    = fetch_valid ? r_mask[w_sel_id] : '0;
    assign w_fire        = fetch_valid & fetch_ready;
    assign busy          = w_busy;

    // Later assignments win, giving exit > resume > launch on the same warp.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_state[i] <= ST_IDLE;
                r_pc[i]    <= '0;
                r_mask[i]  <= '0;
            end
            r_rr      <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else begin
            if (launch_valid && launch_ready) begin
                r_pc[launch_warp_id]    <= launch_pc;
                r_mask[launch_warp_id]  <= launch_mask;
                r_state[launch_warp_id] <= (launch_mask != '0) ? ST_READY : ST_IDLE;
            end
            if (w_fire) begin
                r_state[w_sel_id] <= ST_WAIT;
                r_rr              <= w_sel_id + WARP_W'(1);
                r_lock            <= 1'b0;
            end else if (fetch_valid) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_sel_id;
            end
            if (resume_valid && r_state[resume_warp_id] == ST_WAIT) begin
                r_pc[resume_warp_id]    <= resume_pc;
                r_mask[resume_warp_id]  <= resume_mask;
                r_state[resume_warp_id] <= (resume_mask != '0) ? ST_READY : ST_IDLE;
            end
            if (exit_valid) begin
                r_state[exit_warp_id] <= ST_IDLE;
                // Exiting the presented warp is the one case where valid may drop.
                if (exit_warp_id == w_sel_id) begin
                    r_lock <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
